// File: rtl/api_master.sv
// api_master: issues single read/write transactions to a command/status slave.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   req_valid, req_ready        client request handshake (ready only in IDLE)
//   req_we, req_address,        request fields: 1 = write, 0 = read,
//   req_write_data              target address, write payload
//   resp_valid                  one-cycle completion pulse
//   resp_read_data, resp_error, response fields, held until the next resp_valid
//   resp_timeout
//   command, address,           to slave: 0 IDLE, 1 READ, 3 WRITE
//   write_data
//   status, read_data           from slave: 0 BUSY, 1 READY, 3 ERROR (2 = BUSY)
//   dbg_state_o                 current FSM state, for observation only
//
// Handshake: a request is accepted on a rising edge where req_valid is high
// and the FSM is in IDLE (req_ready high); req_valid in any other state is
// ignored. The slave is driven with a level command that is held until the
// slave reports completion, then dropped; the slave must then report READY
// before the response pulse is issued.
module api_master #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    output logic        resp_valid,
    output logic [31:0] resp_read_data,
    output logic        resp_error,
    output logic        resp_timeout,
    output logic [1:0]  command,
    input  logic [1:0]  status,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_RELEASE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd3;
    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        timeout_hit;
    logic        we_q;
    logic        err_q;
    logic        to_q;
    logic [31:0] rdata_q;

    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_read_data_q;
    logic        resp_error_q;
    logic        resp_timeout_q;
    logic [1:0]  command_q;
    logic [31:0] address_q;
    logic [31:0] write_data_q;

    // The cycle in which the counter would reach TIMEOUT_CYCLES is the last
    // cycle spent in the waiting state.
    assign cnt_d       = cnt_q + 16'd1;
    assign timeout_hit = (cnt_d == TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            cnt_q            <= 16'd0;
            we_q             <= 1'b0;
            err_q            <= 1'b0;
            to_q             <= 1'b0;
            rdata_q          <= 32'd0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_read_data_q <= 32'd0;
            resp_error_q     <= 1'b0;
            resp_timeout_q   <= 1'b0;
            command_q        <= CMD_IDLE;
            address_q        <= 32'd0;
            write_data_q     <= 32'd0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        address_q    <= req_address;
                        write_data_q <= req_write_data;
                        we_q         <= req_we;
                        command_q    <= req_we ? CMD_WRITE : CMD_READ;
                        req_ready_q  <= 1'b0;
                        err_q        <= 1'b0;
                        to_q         <= 1'b0;
                        rdata_q      <= 32'd0;
                        cnt_q        <= 16'd0;
                        state_q      <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Only an explicit BUSY (0) acknowledges the command here.
                    if (status == 2'd0) begin
                        cnt_q   <= 16'd0;
                        state_q <= S_WAIT;
                    end else if (timeout_hit) begin
                        to_q      <= 1'b1;
                        command_q <= CMD_IDLE;
                        cnt_q     <= 16'd0;
                        state_q   <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_WAIT: begin
                    // Status 2 is not a completion code and keeps us waiting.
                    if (status == ST_READY || status == ST_ERROR) begin
                        rdata_q   <= we_q ? 32'd0 : read_data;
                        err_q     <= (status == ST_ERROR);
                        command_q <= CMD_IDLE;
                        cnt_q     <= 16'd0;
                        state_q   <= S_RELEASE;
                    end else if (timeout_hit) begin
                        to_q      <= 1'b1;
                        command_q <= CMD_IDLE;
                        cnt_q     <= 16'd0;
                        state_q   <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RELEASE: begin
                    if (status == ST_READY || timeout_hit) begin
                        // Any timeout, earlier or now, forces read data to 0.
                        resp_valid_q     <= 1'b1;
                        resp_error_q     <= err_q;
                        resp_timeout_q   <= to_q | (status != ST_READY);
                        resp_read_data_q <= (to_q | (status != ST_READY)) ? 32'd0 : rdata_q;
                        cnt_q            <= 16'd0;
                        state_q          <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    req_ready_q <= 1'b1;
                    cnt_q       <= 16'd0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    command_q   <= CMD_IDLE;
                    cnt_q       <= 16'd0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_read_data = resp_read_data_q;
    assign resp_error     = resp_error_q;
    assign resp_timeout   = resp_timeout_q;
    assign command        = command_q;
    assign address        = address_q;
    assign write_data     = write_data_q;
    assign dbg_state_o    = state_q;

endmodule

// File: doc/api_master.md
API_MASTER -- requirements
Module: api_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd1000, max cycles spent in any one waiting state before abort.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  client request present.
REQ-005 req_ready  out  1  master can accept a request; high only in IDLE.
REQ-006 req_we  in  1  1 = write, 0 = read.
REQ-007 req_address  in  32  target address; bits 31:24 select the extension prefix.
REQ-008 req_write_data  in  32  write payload.
REQ-009 resp_valid  out  1  one-cycle pulse: transaction finished.
REQ-010 resp_read_data  out  32  captured read data, valid with resp_valid.
REQ-011 resp_error  out  1  slave returned STATUS_ERROR, valid with resp_valid.
REQ-012 resp_timeout  out  1  transaction aborted by timeout, valid with resp_valid.
REQ-013 command  out  2  to slave: 0 IDLE, 1 READ, 3 WRITE.
REQ-014 status  in  2  from slave: 0 BUSY, 1 READY, 3 ERROR.
REQ-015 address  out  32  to slave.
REQ-016 write_data  out  32  to slave.
REQ-017 read_data  in  32  from slave.

Function
REQ-018 All outputs SHALL be registered; status and read_data SHALL be sampled directly, with no extra input flop.
REQ-019 FSM states: IDLE, REQ, WAIT, RELEASE, RESP; a 16-bit timeout counter SHALL clear on every state entry and increment once per cycle in REQ, WAIT and RELEASE.
REQ-020 IDLE: on req_valid, latch address and write_data, drive command 3 if req_we else 1, set req_ready=0, enter REQ; command becomes visible on the cycle after acceptance.
REQ-021 REQ: status==BUSY -> enter WAIT with command held; counter reaching TIMEOUT_CYCLES first -> set timeout flag, command=0, enter RELEASE.
REQ-022 WAIT: status==READY or ERROR -> capture read_data if read (0 if write), set error flag = (status==ERROR), command=0, enter RELEASE; timeout -> set timeout flag, command=0, enter RELEASE.
REQ-023 WAIT SHALL treat status value 2 as BUSY.
REQ-024 RELEASE: status==READY -> enter RESP; timeout -> set timeout flag, enter RESP.
REQ-025 RESP: resp_valid=1 for exactly one cycle with resp_read_data, resp_error and resp_timeout; next cycle enter IDLE with req_ready=1.
REQ-026 resp_read_data, resp_error and resp_timeout SHALL hold their values until the next resp_valid; each new request SHALL clear the flags at acceptance.
REQ-027 On timeout, resp_read_data SHALL be 0; resp_error and resp_timeout may both be 1 if ERROR was seen before a RELEASE timeout.
REQ-028 address and write_data SHALL stay stable from the cycle command leaves IDLE until RESP.
REQ-029 Back-to-back: a request present during the RESP cycle SHALL be accepted on the following IDLE cycle; minimum request spacing is 1 idle cycle.
REQ-030 req_valid outside IDLE SHALL be ignored and SHALL NOT affect state.

Reset
REQ-031 reset SHALL force IDLE, command=0, address=0, write_data=0, req_ready=1, resp_valid=0, resp_read_data=0, resp_error=0, resp_timeout=0, counter=0.
REQ-032 reset during any state SHALL abort the transaction with no resp_valid pulse; command SHALL be 0 on the cycle after reset.

Verification
REQ-033 Read of 32'h0000_0000 against the bench API slave model (3 wait cycles, returns 32'h6170692d) -> command=1 until status READY, then 0; single resp_valid with resp_read_data=32'h6170692d, resp_error=0, resp_timeout=0.
REQ-034 Write 32'h0000_0010 data 32'h0000_0005, then read 32'h0000_0010 -> second response resp_read_data=32'h0000_0005; write response resp_read_data=0.
REQ-035 Read of 32'h2000_0000 (unmapped prefix; model returns ERROR) -> resp_error=1, command returns to 0, response only after status returns READY.
REQ-036 TIMEOUT_CYCLES=8, status held READY (slave never BUSY) -> command=0 after 8 REQ cycles, resp_valid with resp_timeout=1 and resp_read_data=0 within 10 further cycles.
REQ-037 Assert reset for 1 cycle while in WAIT -> no resp_valid, all outputs at reset values next cycle; a new request then completes normally.
REQ-038 Two requests with req_valid held high continuously -> two accepted transactions, two resp_valid pulses, no overlap of command activity.
